mdu_unit: RTL and testbench

//   Multi-cycle multiply/divide unit with HI/LO registers, in the execute stage.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_unit.sv | 165 ++++++++++++++++
 tb/tb_mdu_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, state encodings and widths for the multiply/divide unit
// Purpose: constants imported by mdu_unit and its bench.
//   OP_*   : 4-bit operation codes presented on op_e
//   state_t: S_IDLE / S_RUN
//   CNT_W  : width of the busy countdown
package mdu_pkg;

    localparam int CNT_W = 4;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
// Purpose: execute-stage MDU. Long ops hold busy for a fixed cycle count and
//   write HI/LO on the last busy edge; mthi/mtlo write in a single cycle.
// Optional feature macro: MDU_MADD_EN (adds madd/maddu/msub/msubu).
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high; clears state, counter, HI and LO
//   start     in   op_e is valid and requests a new operation
//   op_e      in   [3:0] operation code (mdu_pkg OP_*)
//   a_e, b_e  in   [31:0] rs / rt operands
//   busy      out  operation in flight (registered)
//   stall_req out  busy | (start & long op); combinational
//   hi, lo    out  [31:0] HI / LO registers
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op_e,
    input  logic [31:0] a_e,
    input  logic [31:0] b_e,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    function automatic logic is_mul(input logic [3:0] op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic [3:0]       lat_op;
    logic [31:0]      lat_a, lat_b;
    logic             capture;
    logic [31:0]      next_hi, next_lo;

    logic [63:0]      prod_s, prod_u;
    logic [31:0]      mag_a, mag_b, mag_q, mag_r;
    logic [31:0]      uq, ur, sq, sr;
    logic [63:0]      res;
    logic             res_write;

    assign busy      = (state == S_RUN);
    assign stall_req = busy | (start & (is_mul(op_e) | is_div(op_e)));

    // Results come from the latched operands; the multiply-accumulate forms
    // read HI/LO as they stand on the completing edge.
    always_comb begin
        prod_s = {{32{lat_a[31]}}, lat_a} * {{32{lat_b[31]}}, lat_b};
        prod_u = {32'd0, lat_a} * {32'd0, lat_b};

        uq = (lat_b == 32'd0) ? 32'd0 : lat_a / lat_b;
        ur = (lat_b == 32'd0) ? 32'd0 : lat_a % lat_b;

        // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly
        // to 0x80000000 with a zero remainder.
        mag_a = lat_a[31] ? -lat_a : lat_a;
        mag_b = lat_b[31] ? -lat_b : lat_b;
        mag_q = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
        mag_r = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
        sq    = (lat_a[31] ^ lat_b[31]) ? -mag_q : mag_q;
        sr    = lat_a[31] ? -mag_r : mag_r;

        res       = {hi, lo};
        res_write = 1'b1;
        case (lat_op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV: begin
                res       = {sr, sq};
                res_write = (lat_b != 32'd0);
            end
            OP_DIVU: begin
                res       = {ur, uq};
                res_write = (lat_b != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD:  res = {hi, lo} + prod_s;
            OP_MADDU: res = {hi, lo} + prod_u;
            OP_MSUB:  res = {hi, lo} - prod_s;
            OP_MSUBU: res = {hi, lo} - prod_u;
`endif
            default:  res_write = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        capture    = 1'b0;
        next_hi    = hi;
        next_lo    = lo;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (is_mul(op_e)) begin
                        next_state = S_RUN;
                        next_cnt   = CNT_W'(MUL_CYCLES);
                        capture    = 1'b1;
                    end else if (is_div(op_e)) begin
                        next_state = S_RUN;
                        next_cnt   = CNT_W'(DIV_CYCLES);
                        capture    = 1'b1;
                    end else if (op_e == OP_MTHI) begin
                        next_hi = a_e;
                    end else if (op_e == OP_MTLO) begin
                        next_lo = a_e;
                    end
                end
            end
            S_RUN: begin
                // Counter was loaded with N, so the value 1 marks the Nth edge.
                if (cnt <= CNT_W'(1)) begin
                    next_state = S_IDLE;
                    next_cnt   = '0;
                    if (res_write) begin
                        next_hi = res[63:32];
                        next_lo = res[31:0];
                    end
                end else begin
                    next_cnt = cnt - CNT_W'(1);
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            lat_op <= OP_NONE;
            lat_a  <= '0;
            lat_b  <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            hi    <= next_hi;
            lo    <= next_lo;
            if (capture) begin
                lat_op <= op_e;
                lat_a  <= a_e;
                lat_b  <= b_e;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - scoreboard bench for mdu_unit
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op_e;
    logic [31:0] a_e, b_e;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    mdu_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_e      (op_e),
        .a_e       (a_e),
        .b_e       (b_e),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input int cyc);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.cycles = cyc;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_stall);
        @(posedge clk);
        #1;
        start = 1'b1;
        op_e  = op;
        a_e   = a;
        b_e   = b;
        #1;
        check32("stall_req_on_start", {31'd0, stall_req}, {31'd0, exp_stall});
        @(posedge clk);
        #1;
        start = 1'b0;
        op_e  = OP_NONE;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout actual=busy%0d_pending%0d expected=idle", busy, sb.size());
        end
    endtask

    // Monitor: a falling edge of busy is a completed op; compare against the queue.
    initial begin
        int   bc;
        logic pb;
        exp_t e;
        bc = 0;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bc = 0;
                pb = 1'b0;
            end else begin
                if (busy) begin
                    bc++;
                end else if (pb) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion actual=busy_fell expected=no_op_pending");
                    end else begin
                        e = sb.pop_front();
                        check32("sb_hi", hi, e.hi);
                        check32("sb_lo", lo, e.lo);
                        check32("sb_busy_cycles", 32'(bc), 32'(e.cycles));
                    end
                    bc = 0;
                end
                pb = busy;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_e  = OP_NONE;
        a_e   = '0;
        b_e   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        check32("reset_stall", {31'd0, stall_req}, 32'd0);

        // Multiplies and divides
        push(32'hFFFFFFFF, 32'hFFFFFFF1, 5);
        issue(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b1);
        wait_idle();

        push(32'd1, 32'd3, 10);
        issue(OP_DIVU, 32'd7, 32'd2, 1'b1);
        wait_idle();

        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_idle();

        push(32'hFFFFFFFE, 32'h00000001, 5);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_idle();

        push(32'd0, 32'h80000000, 10);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_idle();

        // Divide by zero: full latency, HI/LO untouched
        push(32'd0, 32'h80000000, 10);
        issue(OP_DIVU, 32'd5, 32'd0, 1'b1);
        wait_idle();

        // mthi / mtlo
        issue(OP_MTHI, 32'h12345678, 32'd0, 1'b0);
        @(negedge clk);
        check32("mthi_hi", hi, 32'h12345678);
        check32("mthi_lo", lo, 32'h80000000);
        check32("mthi_busy", {31'd0, busy}, 32'd0);

        issue(OP_MTLO, 32'hCAFEF00D, 32'd0, 1'b0);
        @(negedge clk);
        check32("mtlo_hi", hi, 32'h12345678);
        check32("mtlo_lo", lo, 32'hCAFEF00D);

        // NONE op
        issue(OP_NONE, 32'd11, 32'd22, 1'b0);
        repeat (3) @(negedge clk);
        check32("none_busy", {31'd0, busy}, 32'd0);
        check32("none_hi", hi, 32'h12345678);
        check32("none_lo", lo, 32'hCAFEF00D);

        // Start while busy is ignored
        push(32'd0, 32'd3, 10);
        issue(OP_DIVU, 32'd9, 32'd3, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b1;
        op_e  = OP_MULTU;
        a_e   = 32'd2;
        b_e   = 32'd2;
        #1;
        check32("stall_while_busy", {31'd0, stall_req}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_e  = OP_NONE;
        wait_idle();
        repeat (8) @(negedge clk);
        check32("ignored_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a multiply
        issue(OP_MULT, 32'd3, 32'd3, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check32("midreset_busy", {31'd0, busy}, 32'd0);
        check32("midreset_hi", hi, 32'd0);
        check32("midreset_lo", lo, 32'd0);

        push(32'd0, 32'd42, 5);
        issue(OP_MULT, 32'd7, 32'd6, 1'b1);
        wait_idle();

        // maddu with HI=0, LO=0xFFFFFFFF
        issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
        issue(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
        push(32'd1, 32'd0, 5);
        issue(OP_MADDU, 32'd1, 32'd1, 1'b1);
        wait_idle();
`else
        issue(OP_MADDU, 32'd1, 32'd1, 1'b0);
        repeat (8) @(negedge clk);
        check32("maddu_off_busy", {31'd0, busy}, 32'd0);
        check32("maddu_off_hi", hi, 32'd0);
        check32("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

        repeat (4) @(negedge clk);
        check32("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
